// File: rtl/viterbi_pkg.sv
// Shared types and sizing helpers for the Viterbi post-decode BER checker.
package viterbi_pkg;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  localparam int DEF_MAX_LAT = 64;

  // Width of a lag index for a given history depth; never narrower than one bit.
  function automatic int lag_width(input int max_lat);
    if (max_lat > 1) begin
      return $clog2(max_lat);
    end else begin
      return 1;
    end
  endfunction

  localparam int DEF_LAG_W = lag_width(DEF_MAX_LAT);

endpackage

// File: rtl/viterbi_hist_sr.sv
// Source-bit and valid history shift register with one indexed read port.
module viterbi_hist_sr
  import viterbi_pkg::*;
#(
  parameter int DEPTH = DEF_MAX_LAT,
  parameter int LW    = lag_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          din,
  input  logic          vin,
  input  logic [LW-1:0] sel,
  output logic          dout,
  output logic          vout
);

  logic [DEPTH-1:0] data_r;
  logic [DEPTH-1:0] vld_r;

  // Shift on every clock; the valid history alone decides which taps are live.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= '0;
      vld_r  <= '0;
    end else begin
      data_r <= {data_r[DEPTH-2:0], din};
      vld_r  <= {vld_r[DEPTH-2:0], vin};
    end
  end

  // Read tap L returns the bit shifted in L+1 clocks ago (pre-shift view).
  always_comb begin
    dout = data_r[sel];
    vout = vld_r[sel];
  end

endmodule

// File: rtl/viterbi_ber_checker.sv
// Finds the decode latency by sliding-lag search, then counts post-decode bits and
// residual errors while locked; drops lock and re-searches on an error burst.
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int MAX_LAT  = 64,
  parameter int WIN      = 32,
  parameter int LOCK_THR = 2,
  parameter int LOSS_THR = 8,
  parameter int CW       = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          src_bit_i,
  input  logic                          src_valid_i,
  input  logic                          dec_bit_i,
  input  logic                          clear_i,
  output logic                          locked_o,
  output logic [lag_width(MAX_LAT)-1:0] lag_o,
  output logic [CW-1:0]                 bit_ct_o,
  output logic [CW-1:0]                 err_ct_o,
  output logic [7:0]                    loss_ct_o,
  output logic                          sat_o
);

  localparam int LW = lag_width(MAX_LAT);
  localparam int WW = $clog2(WIN + 1);
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN - 1);
  localparam logic [WW-1:0] LOCK_LIM = WW'(LOCK_THR);
  localparam logic [WW-1:0] LOSS_LIM = WW'(LOSS_THR);
  localparam logic [LW-1:0] LAG_LAST = LW'(MAX_LAT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  state_t        state_r, state_nx_s;
  logic          locked_r;
  logic [LW-1:0] lag_r, lag_nx_s;
  logic [WW-1:0] win_r, win_nx_s;
  logic [WW-1:0] mis_r, mis_nx_s, mis_sum_s;
  logic          loss_s;
  logic [CW-1:0] bit_r, bit_nx_s;
  logic [CW-1:0] err_r, err_nx_s;
  logic          sat_r, sat_nx_s;
  logic [7:0]    loss_ct_r;
  logic          hist_bit_s, hist_vld_s, miss_s, win_end_s;

  function automatic logic [LW-1:0] next_lag(input logic [LW-1:0] l);
    if (l == LAG_LAST) begin
      return '0;
    end else begin
      return l + LW'(1);
    end
  endfunction

  viterbi_hist_sr #(
    .DEPTH(MAX_LAT),
    .LW   (LW)
  ) u_hist (
    .clk (clk),
    .rst (rst),
    .din (src_bit_i),
    .vin (src_valid_i),
    .sel (lag_r),
    .dout(hist_bit_s),
    .vout(hist_vld_s)
  );

  assign miss_s    = hist_bit_s ^ dec_bit_i;
  assign mis_sum_s = mis_r + {{(WW-1){1'b0}}, miss_s};
  assign win_end_s = hist_vld_s && (win_r == WIN_LAST);

  // Window accounting and the SEARCH/TRACK decision taken at each window close.
  always_comb begin
    state_nx_s = state_r;
    lag_nx_s   = lag_r;
    win_nx_s   = win_r;
    mis_nx_s   = mis_r;
    loss_s     = 1'b0;
    if (win_end_s) begin
      win_nx_s = '0;
      mis_nx_s = '0;
      case (state_r)
        SEARCH: begin
          if (mis_sum_s <= LOCK_LIM) begin
            state_nx_s = TRACK;
          end else begin
            lag_nx_s = next_lag(lag_r);
          end
        end
        TRACK: begin
          if (mis_sum_s > LOSS_LIM) begin
            state_nx_s = SEARCH;
            lag_nx_s   = next_lag(lag_r);
            loss_s     = 1'b1;
          end else begin
            state_nx_s = TRACK;
          end
        end
        default: begin
          state_nx_s = SEARCH;
          lag_nx_s   = '0;
        end
      endcase
    end else if (hist_vld_s) begin
      win_nx_s = win_r + WW'(1);
      mis_nx_s = mis_sum_s;
    end else begin
      win_nx_s = win_r;
      mis_nx_s = mis_r;
    end
  end

  // Cumulative counters: clear beats a coincident compare; frozen outside TRACK.
  always_comb begin
    bit_nx_s = bit_r;
    err_nx_s = err_r;
    sat_nx_s = sat_r;
    if (clear_i) begin
      bit_nx_s = '0;
      err_nx_s = '0;
      sat_nx_s = 1'b0;
    end else if ((state_r == TRACK) && hist_vld_s) begin
      if (bit_r != CNT_MAX) begin
        bit_nx_s = bit_r + CW'(1);
      end else begin
        bit_nx_s = bit_r;
      end
      if (miss_s && (err_r != CNT_MAX)) begin
        err_nx_s = err_r + CW'(1);
      end else begin
        err_nx_s = err_r;
      end
      sat_nx_s = sat_r | (bit_nx_s == CNT_MAX) | (err_nx_s == CNT_MAX);
    end else begin
      bit_nx_s = bit_r;
      err_nx_s = err_r;
      sat_nx_s = sat_r;
    end
  end

  // State, window and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= SEARCH;
      locked_r  <= 1'b0;
      lag_r     <= '0;
      win_r     <= '0;
      mis_r     <= '0;
      bit_r     <= '0;
      err_r     <= '0;
      sat_r     <= 1'b0;
      loss_ct_r <= 8'd0;
    end else begin
      state_r  <= state_nx_s;
      locked_r <= (state_nx_s == TRACK);
      lag_r    <= lag_nx_s;
      win_r    <= win_nx_s;
      mis_r    <= mis_nx_s;
      bit_r    <= bit_nx_s;
      err_r    <= err_nx_s;
      sat_r    <= sat_nx_s;
      if (loss_s && (loss_ct_r != 8'hFF)) begin
        loss_ct_r <= loss_ct_r + 8'd1;
      end else begin
        loss_ct_r <= loss_ct_r;
      end
    end
  end

  assign locked_o  = locked_r;
  assign lag_o     = lag_r;
  assign bit_ct_o  = bit_r;
  assign err_ct_o  = err_r;
  assign loss_ct_o = loss_ct_r;
  assign sat_o     = sat_r;

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Downstream checker for the convolutional-encoder / channel / Viterbi-decoder chain. It consumes the decoder output bit stream and the original encoder input stream. It finds the unknown decode latency automatically and locks onto it, then counts decoded bits and residual bit errors for post-decode BER measurement. If the error rate rises past a threshold, it drops lock and re-searches.

## Interface
Parameters:
- MAX_LAT, 64: size of the history buffer; candidate lags are 0..MAX_LAT-1.
- WIN, 32: number of compared bits per evaluation window.
- LOCK_THR, 2: maximum mismatches in a window for SEARCH to declare lock.
- LOSS_THR, 8: window mismatches above this value drop lock.
- CW, 32: width of the cumulative counters.

Ports:
- clk  in  1  clock. Reset rst is asynchronous, active-low; clock clk.
- rst  in  1  asynchronous active-low reset.
- src_bit_i  in  1  encoder input bit.
- src_valid_i  in  1  encoder enable; qualifies src_bit_i.
- dec_bit_i  in  1  decoder output bit.
- clear_i  in  1  synchronous clear of the cumulative counters and sat_o.
- locked_o  out  1  lag found; checker is in TRACK.
- lag_o  out  $clog2(MAX_LAT)  current lag candidate, or the locked lag.
- bit_ct_o  out  CW  decoded bits compared while locked.
- err_ct_o  out  CW  mismatches counted while locked.
- loss_ct_o  out  8  number of lock losses; saturating.
- sat_o  out  1  sticky; set when any counter saturates.

## Operation
- History shift register: every posedge, hist <= {hist[MAX_LAT-2:0], src_bit_i} and hv <= {hv[MAX_LAT-2:0], src_valid_i}. Shifting happens on every clock, independent of src_valid_i.
- Compare event: at a posedge where hv[L] == 1, compare dec_bit_i against hist[L], using pre-shift values. Lag L therefore means the decoded bit equals the source bit from L+1 clocks earlier. When hv[L] == 0, nothing is compared or counted.
- Each compare event increments the window count w. A mismatch also increments the window mismatch count m.
- States are SEARCH and TRACK. Reset enters SEARCH with L = 0.
- SEARCH, at the compare that makes w = WIN (that compare is included):
  - if m <= LOCK_THR, go to TRACK with lag_o = L;
  - otherwise L <= (L+1) mod MAX_LAT.
  - In both cases clear w and m.
- TRACK:
  - Each compare adds 1 to bit_ct_o, and adds 1 to err_ct_o on a mismatch.
  - At window end, if m > LOSS_THR: go to SEARCH with L <= (lag+1) mod MAX_LAT, and loss_ct_o increments. Otherwise stay in TRACK.
  - w and m clear at every window end.
- Cumulative counters are frozen while in SEARCH.
- Saturation: bit_ct_o, err_ct_o and loss_ct_o stop at all-ones. sat_o sets when bit_ct_o or err_ct_o saturates. sat_o is cleared only by clear_i or reset.
- clear_i coinciding with a compare: clear wins. The coincident bit is not added to the cumulative counters but still counts in w and m.
- clear_i does not affect state, L, w, m or loss_ct_o.

## Timing
- Reset (asynchronous, any state, including mid-TRACK):
  - locked_o = 0, lag_o = 0, bit_ct_o = 0, err_ct_o = 0, loss_ct_o = 0, sat_o = 0;
  - hv cleared; w = 0, m = 0; state SEARCH.
- All outputs are registered.
- Counters reflect a compare one clock after the posedge at which it was sampled.
- locked_o rises, and lag_o holds the lock value, on the posedge that closes the qualifying window. locked_o falls on the posedge that closes the losing window.
- Minimum lock time is WIN compares, since the first window is never skipped.
- After reset, the first MAX_LAT clocks produce compares only once hv has filled up to position L.

## Structure
- Shared package viterbi_pkg holds:
  - the state typedef (enum SEARCH, TRACK);
  - the lag width as a localparam function of MAX_LAT.
- One sub-module, viterbi_hist_sr: a parameterised MAX_LAT-deep data/valid shift register with an indexed read port (L in, bit and valid out).
- The FSM, window logic and counters stay in the top module.

## Test plan
- Reset check: apply rst low mid-stream → all outputs 0, locked_o 0, lag_o 0. Release reset → search restarts at L = 0.
- Clean lock: continuous valid PRBS with dec_bit_i = src delayed 20 clocks → locked_o = 1 with lag_o = 19 after 20 windows of 32 compares. err_ct_o stays 0 and bit_ct_o increments by 1 per clock.
- Light errors: while locked, flip 3 decoded bits within one window → err_ct_o += 3, locked_o stays 1, loss_ct_o = 0.
- Burst: flip 12 bits in one window → locked_o falls at window end and loss_ct_o = 1. Search resumes at L = 20, wraps modulo 64, and relocks at lag 19.
- Valid gaps: src_valid_i toggling 1,0,1,0 with the same lag → compares only on valid slots. bit_ct_o equals the number of valid source bits past lock, and lock takes 2× the clocks.
- Saturation/clear: with CW=4 and a stuck-wrong decoder at locked lag (LOSS_THR = WIN) → err_ct_o stops at 15 and sat_o = 1. Pulse clear_i → counters 0, sat_o 0, locked_o unchanged.
